nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Sequential WIDTH-bit adder: one 4-bit ripple-carry slice, reused once per nibble, LSB nibble first.
//  Carry is held in a register between cycles.
//  Upstream and downstream sides each use a valid/ready handshake.
//  Datapath stage for wide operands where one 4-bit ripple slice is the area budget.
// PARAMETERS
//  WIDTH    16              operand/sum width; must be a multiple of 4 (elaboration error otherwise)
//  NIBBLES  WIDTH/4         derived (localparam); slice iterations per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/c_in valid
//  in_ready   out  1      block can accept (high only in IDLE)
//  in1        in   WIDTH  operand A, sampled only at accept
//  in2        in   WIDTH  operand B, sampled only at accept
//  c_in       in   1      carry-in, sampled only at accept
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  (in1+in2+c_in) mod 2^WIDTH
//  c_out      out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (present only with SIGNED_OVF_EN)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, sum=0, c_out=0, ovf=0, out_valid=0.
//   in_ready=(state==IDLE), so in_ready=1 during and after reset.
//  FSM: IDLE -> RUN on in_valid&&in_ready. On that edge:
//   - latch in1/in2 into shift registers
//   - carry_reg<=c_in, nib_cnt<=0
//  RUN: each cycle the slice adds A[3:0]+B[3:0]+carry_reg.
//   - 4-bit result shifts into sum from the MSB end; A/B shift right 4
//   - carry_reg <= slice carry; nib_cnt++
//   - nib_cnt==NIBBLES-1 -> DONE; c_out<=slice carry on the same edge
//  DONE: out_valid=1; sum/c_out/ovf held stable until out_valid&&out_ready, then -> IDLE.
//  Latency: accept edge E0; out_valid high after edge E_NIBBLES (4 cycles at WIDTH=16).
//  Min period is NIBBLES+2 cycles: one DONE cycle, one IDLE bubble.
//  No overlap: in_valid ignored in RUN/DONE; out_ready ignored outside DONE.
//  out_ready high on the first DONE cycle -> IDLE next edge.
//  Arithmetic unsigned modulo 2^WIDTH; the carry ripples across all nibbles, e.g. FFFF+1.
//  Reset mid-RUN/DONE: operation aborted, result discarded, outputs to reset values.
//  sum holds the partial result in RUN; it is valid only when out_valid=1.
// CONFIGURATION
//  SIGNED_OVF_EN defined:
//   - port ovf exists
//   - set on the final nibble edge: (A[3]==B[3]) && (slice_sum[3]!=A[3]) for the MSB nibble
//   - held in DONE; reset 0
//  SIGNED_OVF_EN undefined: no ovf port, no ovf logic; all else identical.
// STRUCTURE
//  Package adder_pkg:
//   - NIBBLE_W=4
//   - state typedef {IDLE, RUN, DONE}, 2-bit encoding
//  Sub-module rca_nibble_slice: combinational 4-bit ripple-carry adder (a, b, ci -> s, co).
//   Built from four full-adder cells; instantiated once.
//  Top holds FSM, nib_cnt ($clog2(NIBBLES) bits), operand shift registers, carry_reg, result register.
// TESTING (WIDTH=16; every result checked against in1+in2+c_in)
//  1. 0x0004+0x0004, c_in=0 -> sum=0x0008, c_out=0; out_valid exactly 4 cycles after accept.
//  2. 0xFFFF+0x0001, c_in=0 -> sum=0x0000, c_out=1 (full carry ripple across nibbles).
//  3. 0x7FFF+0x0001 -> sum=0x8000, c_out=0, ovf=1;
//     0x8000+0x8000 -> sum=0x0000, c_out=1, ovf=1 (ovf checks only with SIGNED_OVF_EN).
//  4. 0x0003+0x0002, c_in=1 -> 0x0006, with out_ready low for 5 DONE cycles:
//     - sum/out_valid stable; in_ready=0
//     - an in_valid pulse during the stall is ignored
//  5. rst_n low after 2 RUN cycles of 0xABCD+0x1111:
//     - out_valid=0, sum=0, in_ready=1 immediately
//     - then 0x1234+0x4321 -> 0x5555, c_out=0
//  6. Back-to-back ops with out_ready=1, in_valid=1: one result every 6 cycles;
//     100 random operand/c_in pairs match the reference model.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared constants and FSM state type for the nibble-serial adder.
//   NIBBLE_W : width of the reused ripple-carry slice
//   state_t  : controller states IDLE / RUN / DONE (2-bit encoding)
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rca_nibble_slice.sv
// rca_nibble_slice: combinational 4-bit ripple-carry adder built from four full-adder cells.
//   a, b : nibble operands
//   ci   : carry into bit 0
//   s    : nibble sum
//   co   : carry out of bit 3
module rca_nibble_slice
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic [NIBBLE_W:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign co = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple slice per nibble, LSB first.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake; in1, in2, c_in sampled only at accept
//   out_valid/out_ready : downstream handshake; sum, c_out (and ovf) valid while out_valid
//   sum, c_out          : (in1+in2+c_in) mod 2^WIDTH and carry out of bit WIDTH-1
//   ovf                 : signed overflow, present only when SIGNED_OVF_EN is defined
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_chk
      $error("nibble_serial_adder: WIDTH must be a nonzero multiple of 4");
   end

   state_t               r_state, w_state_nx;
   logic [WIDTH-1:0]     r_a, r_b, r_sum;
   logic [CW-1:0]        r_cnt;
   logic                 r_carry, r_c_out;
   logic [NIBBLE_W-1:0]  w_s;
   logic                 w_co, w_last;

   rca_nibble_slice u_slice (
      .a  (r_a[NIBBLE_W-1:0]),
      .b  (r_b[NIBBLE_W-1:0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last    = r_cnt == CW'(NIBBLES - 1);
   assign in_ready  = r_state == IDLE;
   assign out_valid = r_state == DONE;
   assign sum       = r_sum;
   assign c_out     = r_c_out;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nx = RUN;
         RUN:     if (w_last)    w_state_nx = DONE;
         DONE:    if (out_ready) w_state_nx = IDLE;
         default:                w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   // Each slice result enters at the top of sum so after NIBBLES shifts the LSB nibble sits at bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
      end else if (r_state == IDLE && in_valid) begin
         r_a     <= in1;
         r_b     <= in2;
         r_carry <= c_in;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> NIBBLE_W;
         r_b     <= r_b >> NIBBLE_W;
         r_sum   <= (r_sum >> NIBBLE_W) | (WIDTH'(w_s) << (WIDTH - NIBBLE_W));
         r_carry <= w_co;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) r_c_out <= w_co;
      end
   end

`ifdef SIGNED_OVF_EN
   logic r_ovf;

   // On the last nibble the low bits of the shifted operands are the operand MSB nibbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_ovf <= 1'b0;
      else if (r_state == RUN && w_last) r_ovf <= (r_a[NIBBLE_W-1] == r_b[NIBBLE_W-1]) && (w_s[NIBBLE_W-1] != r_a[NIBBLE_W-1]);
   end

   assign ovf = r_ovf;
`endif

endmodule
